// File: rtl/dest_reg_pipe_if.sv
// Bundle between ID decode and the destination-register tracking pipeline.
// The master drives the decode slot; the slave returns per-stage tags and forwarding hits.
interface dest_reg_pipe_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int DEPTH   = 3
);
  logic                      stall;
  logic                      flush;
  logic                      in_valid;
  logic                      reg_write;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [SEL_W-1:0]          sel;
  logic [ADDR_W-1:0]         rs_addr;
  logic [ADDR_W-1:0]         rt_addr;
  logic [DEPTH*ADDR_W-1:0]   stage_addr;
  logic [DEPTH-1:0]          stage_we;
  logic [ADDR_W-1:0]         wb_addr;
  logic                      wb_we;
  logic [DEPTH-1:0]          fwd_rs;
  logic [DEPTH-1:0]          fwd_rt;
  logic                      sel_err;

  modport master (
    output stall, flush, in_valid, reg_write, src_addr, sel, rs_addr, rt_addr,
    input  stage_addr, stage_we, wb_addr, wb_we, fwd_rs, fwd_rt, sel_err
  );

  modport slave (
    input  stall, flush, in_valid, reg_write, src_addr, sel, rs_addr, rt_addr,
    output stage_addr, stage_we, wb_addr, wb_we, fwd_rs, fwd_rt, sel_err
  );
endinterface

// File: rtl/dest_reg_pipe.sv
// Destination-register select and DEPTH-stage tag pipeline with stall/flush handling
// and youngest-wins forwarding hit detection for two source operands.
module dest_reg_pipe #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int DEPTH   = 3
) (
  input logic            clk,
  input logic            reset_n,
  dest_reg_pipe_if.slave bus
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DEPTH-1:0]  we_q;
  logic [DEPTH-1:0]  we_d;
  logic              err_q;
  logic              err_d;

  logic [ADDR_W-1:0] cand;
  logic              sel_bad;
  logic              we_new;

  // Out-of-range selects match no candidate, so cand falls back to 0.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.sel == SEL_W'(i)) cand = bus.src_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign sel_bad = ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_SRC));
  assign we_new  = bus.in_valid & bus.reg_write & ~sel_bad & (cand != '0);

  always_comb begin
    addr_d = addr_q;
    we_d   = we_q;
    err_d  = err_q;
    if (bus.flush) begin
      addr_d[0] = '0;
      we_d[0]   = 1'b0;
    end else if (!bus.stall) begin
      addr_d[0] = cand;
      we_d[0]   = we_new;
      err_d     = sel_bad & bus.in_valid;
    end
    // Only stage 1 sees the stall bubble; on flush it still drains the old stage 0.
    for (int k = 1; k < DEPTH; k++) begin
      if (k == 1 && bus.stall && !bus.flush) begin
        addr_d[k] = '0;
        we_d[k]   = 1'b0;
      end else begin
        addr_d[k] = addr_q[k-1];
        we_d[k]   = we_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '{default: '0};
      we_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      we_q   <= we_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    bus.stage_addr = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.stage_addr[k*ADDR_W +: ADDR_W] = addr_q[k];
    end
  end

  assign bus.stage_we = we_q;
  assign bus.wb_addr  = addr_q[DEPTH-1];
  assign bus.wb_we    = we_q[DEPTH-1];
  assign bus.sel_err  = err_q;

  // Scan oldest to youngest so the youngest matching stage overwrites the result.
  always_comb begin
    bus.fwd_rs = '0;
    bus.fwd_rt = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (we_q[k] && addr_q[k] == bus.rs_addr && bus.rs_addr != '0) begin
        bus.fwd_rs    = '0;
        bus.fwd_rs[k] = 1'b1;
      end
      if (we_q[k] && addr_q[k] == bus.rt_addr && bus.rt_addr != '0) begin
        bus.fwd_rt    = '0;
        bus.fwd_rt[k] = 1'b1;
      end
    end
  end

endmodule
